// File: rtl/sort4_gather.sv
// Packs a serial valid/ready sample stream into quads for the 4-input sorter.
// A fill register collects samples while the output register holds the previous quad.
module sort4_gather #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  output logic [W-1:0] c,
  output logic [W-1:0] d,
  output logic [2:0]   q_count,
  output logic         q_valid,
  input  logic         q_ready
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t       state_q;
  logic [1:0]   idx_q;
  logic [W-1:0] s0_q, s1_q, s2_q, s3_q;
  logic [2:0]   hcnt_q;
  logic [W-1:0] a_q, b_q, c_q, d_q;
  logic [2:0]   cnt_q;
  logic         vld_q;

  logic         acc, done, out_free;
  logic [W-1:0] g0_d, g1_d, g2_d, g3_d;
  logic [2:0]   gcnt_d;

  assign in_ready = (state_q == COLLECT);
  assign acc      = in_valid && in_ready;
  assign done     = acc && ((idx_q == 2'd3) || in_last);
  assign out_free = !vld_q || q_ready;
  assign gcnt_d   = {1'b0, idx_q} + 3'd1;

  // Completed group: earlier slots from the fill register, current sample at idx,
  // zeros above it (stale slot contents from older groups must not leak through).
  always_comb begin
    g0_d = (idx_q == 2'd0) ? in_data : s0_q;
    g1_d = (idx_q == 2'd1) ? in_data : ((idx_q > 2'd1) ? s1_q : '0);
    g2_d = (idx_q == 2'd2) ? in_data : ((idx_q == 2'd3) ? s2_q : '0);
    g3_d = (idx_q == 2'd3) ? in_data : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      hcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      // Default: a consumed quad drops q_valid unless a new one loads below.
      if (vld_q && q_ready) vld_q <= 1'b0;
      if (state_q == COLLECT) begin
        if (acc && !done) begin
          if (idx_q == 2'd0) s0_q <= in_data;
          else if (idx_q == 2'd1) s1_q <= in_data;
          else s2_q <= in_data;
          idx_q <= idx_q + 2'd1;
        end else if (done && out_free) begin
          a_q     <= g0_d;
          b_q     <= g1_d;
          c_q     <= g2_d;
          d_q     <= g3_d;
          cnt_q   <= gcnt_d;
          vld_q   <= 1'b1;
          idx_q   <= '0;
        end else if (done) begin
          s0_q    <= g0_d;
          s1_q    <= g1_d;
          s2_q    <= g2_d;
          s3_q    <= g3_d;
          hcnt_q  <= gcnt_d;
          state_q <= HOLD;
        end
      end else if (q_ready) begin
        // q_valid is always high in HOLD, so q_ready here is an output transfer.
        a_q     <= s0_q;
        b_q     <= s1_q;
        c_q     <= s2_q;
        d_q     <= s3_q;
        cnt_q   <= hcnt_q;
        vld_q   <= 1'b1;
        idx_q   <= '0;
        state_q <= COLLECT;
      end
    end
  end

  assign a       = a_q;
  assign b       = b_q;
  assign c       = c_q;
  assign d       = d_q;
  assign q_count = cnt_q;
  assign q_valid = vld_q;

endmodule

// File: tb/tb_sort4_gather.sv
// Directed bench for sort4_gather: hand-computed quads, stalls, flushes and resets.
module tb_sort4_gather;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic [3:0] a, b, c, d;
  logic [2:0] q_count;
  logic       q_valid;
  logic       q_ready = 1'b0;

  int n_run = 0;
  int n_fail = 0;

  sort4_gather #(.W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .a(a), .b(b), .c(c), .d(d),
    .q_count(q_count), .q_valid(q_valid), .q_ready(q_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkq(input string tag, input int ea, input int eb, input int ec,
                      input int ed, input int en);
    chk({tag, ".q_valid"}, int'(q_valid), 1);
    chk({tag, ".a"}, int'(a), ea);
    chk({tag, ".b"}, int'(b), eb);
    chk({tag, ".c"}, int'(c), ec);
    chk({tag, ".d"}, int'(d), ed);
    chk({tag, ".q_count"}, int'(q_count), en);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int v, input bit last);
    in_valid = 1'b1;
    in_data  = 4'(v);
    in_last  = last;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".q_valid"}, int'(q_valid), 0);
    chk({tag, ".in_ready"}, int'(in_ready), 1);
    chk({tag, ".a"}, int'(a), 0);
    chk({tag, ".d"}, int'(d), 0);
    chk({tag, ".q_count"}, int'(q_count), 0);
  endtask

  initial begin
    #1;
    chk_reset_vals("rst0");
    step(); step();
    rst_n = 1'b1;
    step();
    chk_reset_vals("post_rst");

    // Basic quad, consumer always ready
    q_ready = 1'b1;
    put(9, 0);  chk("t1.rdy1", int'(in_ready), 1);
    put(3, 0);  chk("t1.rdy2", int'(in_ready), 1);
    put(12, 0); chk("t1.rdy3", int'(in_ready), 1);
    put(5, 0);  chk("t1.rdy4", int'(in_ready), 1);
    chkq("t1", 9, 3, 12, 5, 4);
    idle();
    chk("t1.drop", int'(q_valid), 0);

    // Eight back-to-back samples, quads exactly 4 cycles apart
    for (int i = 1; i <= 8; i++) begin
      put(i, 0);
      chk("t2.rdy", int'(in_ready), 1);
      if (i == 4) chkq("t2.q1", 1, 2, 3, 4, 4);
      else if (i == 8) chkq("t2.q2", 5, 6, 7, 8, 4);
      else chk("t2.gap", int'(q_valid), 0);
    end
    idle();

    // Stalled consumer: second quad parks in the fill register
    q_ready = 1'b0;
    for (int i = 1; i <= 8; i++) put(i, 0);
    chkq("t3.held", 1, 2, 3, 4, 4);
    chk("t3.rdy_low", int'(in_ready), 0);
    put(9, 0);
    chk("t3.rdy_low2", int'(in_ready), 0);
    chkq("t3.stable", 1, 2, 3, 4, 4);
    q_ready = 1'b1;
    step();
    chkq("t3.q2", 5, 6, 7, 8, 4);
    chk("t3.rdy_back", int'(in_ready), 1);
    put(9, 0);
    chk("t3.drain", int'(q_valid), 0);
    put(10, 0); put(11, 0); put(12, 0);
    chkq("t3.q3", 9, 10, 11, 12, 4);
    idle();

    // Partial flush pads with zero despite stale slots; next group starts at a
    put(7, 0); put(2, 1);
    chkq("t4.flush", 7, 2, 0, 0, 2);
    put(1, 0); put(2, 0); put(3, 0); put(4, 0);
    chkq("t4.next", 1, 2, 3, 4, 4);
    put(15, 1);
    chkq("t5.single", 15, 0, 0, 0, 1);
    idle();
    put(6, 0);
    put(13, 1);
    chkq("t5.pair", 6, 13, 0, 0, 2);
    idle();

    // Reset mid-group with an unconsumed quad pending
    q_ready = 1'b0;
    put(1, 0); put(2, 0); put(3, 0); put(4, 0);
    put(8, 0); put(9, 0);
    in_valid = 1'b0;
    chk("t6.pending", int'(q_valid), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t6.async");
    step();
    rst_n = 1'b1;
    q_ready = 1'b1;
    idle(); idle(); idle();
    chk("t6.no_stale", int'(q_valid), 0);
    put(5, 0); put(6, 0); put(7, 0); put(8, 0);
    chkq("t6.fresh", 5, 6, 7, 8, 4);
    idle();

    // Reset while in HOLD
    q_ready = 1'b0;
    for (int i = 1; i <= 8; i++) put(i + 2, 0);
    in_valid = 1'b0;
    chk("t7.hold", int'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t7.async");
    step();
    rst_n = 1'b1;
    q_ready = 1'b1;
    idle(); idle(); idle();
    chk("t7.no_stale", int'(q_valid), 0);
    put(14, 0); put(0, 0); put(11, 0); put(4, 0);
    chkq("t7.fresh", 14, 0, 11, 4, 4);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/sort4_gather.md
# sort4_gather

Upstream stage for the four-input descending sort network. Accepts a serial stream of W-bit samples over a valid/ready handshake and packs each group of four into one parallel quad, which the sorter consumes as its a/b/c/d inputs. A two-level buffer (fill register plus output register) keeps the stream collecting while a finished quad waits to be consumed. A last-sample marker flushes partial groups, padding unused slots with zero; zeros sort to the bottom of a descending sort.

## Interface
- W, default 4, sample width (matches sorter operand width)
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_data  input  W  incoming sample
- in_valid  input  1  in_data valid this cycle
- in_last  input  1  qualifies in_valid; sample closes the current group
- in_ready  output  1  block accepts a sample this cycle
- a, b, c, d  output  W each  packed quad to the sorter; a = first sample of group
- q_count  output  3  number of real samples in quad, 1..4
- q_valid  output  1  quad on a/b/c/d/q_count valid
- q_ready  input  1  consumer takes the quad this cycle

## Operation
- Transfers:
  - Input transfer = in_valid && in_ready at a rising edge.
  - Output transfer = q_valid && q_ready at a rising edge.
- Fill register: slots s0..s2 plus 2-bit index idx (next slot, 0..3).
- States:
  - COLLECT (reset state): in_ready = 1.
  - HOLD: complete group waiting for the output register; in_ready = 0.
- Group completion: input transfer with idx == 3 or in_last == 1.
  - Slot idx takes in_data; slots above idx take 0.
  - Group count = idx + 1.
- Output register free this cycle = !q_valid || q_ready.
- COLLECT, input transfer, group not complete:
  - Write s[idx] = in_data; idx += 1.
- COLLECT, group complete, output register free:
  - Load a..d and q_count from the completed group; q_valid = 1 next cycle.
  - idx = 0; stay in COLLECT.
- COLLECT, group complete, output register not free:
  - Store the completed group (including the final sample and zero padding) in the fill register.
  - Go to HOLD.
- HOLD, output transfer: load the held group into the output register (q_valid stays 1); idx = 0; go to COLLECT.
- HOLD, no output transfer: no change.
- Output transfer with no new group loading in the same cycle: q_valid = 0. a..d and q_count keep their values.
- Output register contents stay stable while q_valid && !q_ready.
- Ignored inputs:
  - in_valid while in_ready == 0. Source must hold in_data/in_last.
  - in_last without in_valid.
  - q_ready while q_valid == 0.
- Idle: no input activity leaves a partial group pending indefinitely; there is no timeout.

## Timing
- Reset (async assert, synchronous-release use): state = COLLECT, idx = 0, s0..s2 = 0, a..d = 0, q_count = 0, q_valid = 0. in_ready = 1 from the first cycle after reset.
- Reset mid-group or during HOLD discards all pending samples; no quad is emitted.
- Latency: q_valid rises on the edge that accepts the group's final sample, so it is visible the next cycle.
- Throughput with q_ready held high: one sample per cycle sustained; one quad every 4 cycles; in_ready never deasserts.
- A full group arriving while the previous quad is unconsumed:
  - in_ready falls the cycle after acceptance.
  - in_ready returns to 1 the cycle after the output transfer.
  - No sample is lost or duplicated.
- in_ready is a function of state only; it has no combinational path from q_ready.
- Simultaneous output transfer and group completion: the new quad replaces the old one with no bubble, and q_valid stays 1.

## Test plan
- Reset, then q_ready = 1 and stream 9,3,12,5 with in_valid on consecutive cycles:
  - Cycle after the 4th sample: q_valid = 1, a = 9, b = 3, c = 12, d = 5, q_count = 4.
  - in_ready stays 1 throughout.
- Eight back-to-back samples 1..8 with q_ready = 1: two quads (1,2,3,4) then (5,6,7,8), exactly 4 cycles apart, no stall.
- q_ready = 0, send 8 samples:
  - First quad is held.
  - After the 8th sample in_ready = 0 and the 9th sample is not accepted.
  - Pulse q_ready: second quad appears the next cycle; in_ready returns to 1.
- Partial flush: samples 7 then 2 with in_last on the second → a = 7, b = 2, c = 0, d = 0, q_count = 2. The next group starts at slot a.
- Single sample 15 with in_last → a = 15, b = c = d = 0, q_count = 1.
- Assert rst_n = 0 after 2 samples of a group, and separately during HOLD:
  - All outputs return to reset values immediately; q_valid = 0.
  - No stale quad appears after release.
  - A fresh 4-sample group packs correctly.
